// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC execution sequencer.
package npc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      NPC_SEQ,
      NPC_JUMP,
      NPC_TRAP,
      NPC_MRET
   } npc_sel_e;

   localparam logic [31:0] MCAUSE_ECALL_M  = 32'd11;
   localparam int          MEM_TIMEOUT_DEF = 255;

   // Trap beats mret beats jump; anything else falls through to pc+4.
   function automatic npc_sel_e npc_select(input logic intr, input logic mret, input logic jump);
      if (intr)      return NPC_TRAP;
      else if (mret) return NPC_MRET;
      else if (jump) return NPC_JUMP;
      else           return NPC_SEQ;
   endfunction

endpackage

// File: rtl/npc_exec_ctrl_if.sv
// Sequencer-facing bundle: fetch, decode class, LSU handshake, commit strobes, status.
interface npc_exec_ctrl_if #(parameter int CNT_W = 64);
   logic [31:0]      pc;
   logic             ifu_req;
   logic             ifu_ack;
   logic             exu_valid;
   logic             dec_read;
   logic             dec_write;
   logic             dec_reg_wen;
   logic             dec_csr_wen;
   logic             dec_intr;
   logic             dec_mret;
   logic             dec_halt;
   logic             dec_illegal;
   logic             jump;
   logic [31:0]      jump_target;
   logic [31:0]      mtvec;
   logic [31:0]      mepc;
   logic             lsu_req;
   logic             lsu_we;
   logic             lsu_ack;
   logic             lsu_err;
   logic             rf_wen;
   logic             csr_wen;
   logic             trap_take;
   logic             retire;
   logic             halt;
   logic             halt_err;
   logic [CNT_W-1:0] retire_cnt;
   logic [CNT_W-1:0] cycle_cnt;

   modport ctrl (
      output pc, ifu_req, exu_valid, lsu_req, lsu_we, rf_wen, csr_wen,
             trap_take, retire, halt, halt_err, retire_cnt, cycle_cnt,
      input  ifu_ack, dec_read, dec_write, dec_reg_wen, dec_csr_wen, dec_intr,
             dec_mret, dec_halt, dec_illegal, jump, jump_target, mtvec, mepc,
             lsu_ack, lsu_err
   );

   modport env (
      input  pc, ifu_req, exu_valid, lsu_req, lsu_we, rf_wen, csr_wen,
             trap_take, retire, halt, halt_err, retire_cnt, cycle_cnt,
      output ifu_ack, dec_read, dec_write, dec_reg_wen, dec_csr_wen, dec_intr,
             dec_mret, dec_halt, dec_illegal, jump, jump_target, mtvec, mepc,
             lsu_ack, lsu_err
   );
endinterface

// File: rtl/npc_ctrl_wdt.sv
// MEM-state watchdog: counts enabled cycles, flags the last allowed cycle.
module npc_ctrl_wdt #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(LIMIT) + 1;

   logic [W-1:0] cnt_q, cnt_d;

   // Count holds k-1 during the k-th MEM cycle, so expiry lands on cycle LIMIT.
   assign expired_o = (cnt_q == W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                  cnt_d = '0;
      else if (en_i && !expired_o) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/npc_exec_ctrl.sv
// Multi-cycle NPC sequencer: fetch/exec/mem/writeback, PC ownership and commit strobes.
module npc_exec_ctrl
   import npc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int          CNT_W       = 64
) (
   input  logic              clk,
   input  logic              rst,
   npc_exec_ctrl_if.ctrl     bus
);
   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             halt_err_q, halt_err_d;
   logic [CNT_W-1:0] retire_cnt_q, cycle_cnt_q;
   logic             wdt_expired;
   npc_sel_e         npc_sel;
   logic [31:0]      npc;
   logic             npc_bad;
   logic             wb_ok;

   npc_ctrl_wdt #(.LIMIT(MEM_TIMEOUT)) u_wdt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q != ST_MEM),
      .en_i      (state_q == ST_MEM),
      .expired_o (wdt_expired)
   );

   always_comb begin
      npc_sel = npc_select(bus.dec_intr, bus.dec_mret, bus.jump);
      case (npc_sel)
         NPC_TRAP: npc = bus.mtvec;
         NPC_MRET: npc = bus.mepc;
         NPC_JUMP: npc = bus.jump_target;
         default:  npc = pc_q + 32'd4;
      endcase
   end

   assign npc_bad = |npc[1:0];
   // A misaligned target suppresses every WB side effect, not just the PC update.
   assign wb_ok   = (state_q == ST_WB) && !npc_bad;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      halt_err_d = halt_err_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: if (bus.ifu_ack) state_d = ST_EXEC;
         ST_EXEC: begin
            if (bus.dec_illegal || (bus.dec_read && bus.dec_write)) begin
               state_d    = ST_HALT;
               halt_err_d = 1'b1;
            end else if (bus.dec_halt) begin
               state_d = ST_HALT;
            end else if (bus.dec_read || bus.dec_write) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (bus.lsu_ack) begin
               if (bus.lsu_err) begin
                  state_d    = ST_HALT;
                  halt_err_d = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wdt_expired) begin
               state_d    = ST_HALT;
               halt_err_d = 1'b1;
            end
         end
         ST_WB: begin
            if (npc_bad) begin
               state_d    = ST_HALT;
               halt_err_d = 1'b1;
            end else begin
               state_d = ST_FETCH;
               pc_d    = npc;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         halt_err_q   <= 1'b0;
         retire_cnt_q <= '0;
         cycle_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         halt_err_q   <= halt_err_d;
         cycle_cnt_q  <= cycle_cnt_q + CNT_W'(1);
         if (wb_ok) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
   end

   assign bus.pc         = pc_q;
   assign bus.ifu_req    = (state_q == ST_FETCH);
   assign bus.exu_valid  = (state_q == ST_EXEC);
   assign bus.lsu_req    = (state_q == ST_MEM);
   assign bus.lsu_we     = (state_q == ST_MEM) && bus.dec_write;
   assign bus.retire     = wb_ok;
   assign bus.rf_wen     = wb_ok && bus.dec_reg_wen && !bus.dec_intr;
   assign bus.csr_wen    = wb_ok && bus.dec_csr_wen;
   assign bus.trap_take  = wb_ok && bus.dec_intr;
   assign bus.halt       = (state_q == ST_HALT);
   assign bus.halt_err   = halt_err_q;
   assign bus.retire_cnt = retire_cnt_q;
   assign bus.cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Directed bench for npc_exec_ctrl: hand-computed expectations checked with immediate asserts.
module tb_npc_exec_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   npc_exec_ctrl_if #(.CNT_W(64)) bus ();

   npc_exec_ctrl #(
      .RESET_PC    (32'h8000_0000),
      .MEM_TIMEOUT (255),
      .CNT_W       (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then let outputs and freshly driven inputs settle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_dec();
      bus.dec_read = 0; bus.dec_write = 0; bus.dec_reg_wen = 0; bus.dec_csr_wen = 0;
      bus.dec_intr = 0; bus.dec_mret = 0; bus.dec_halt = 0; bus.dec_illegal = 0;
      bus.jump = 0;
   endtask

   // Called in FETCH: ack immediately, return in EXEC.
   task automatic fetch();
      bus.ifu_ack = 1;
      cyc();
      bus.ifu_ack = 0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      cyc();
      rst = 0;
      #1;
   endtask

   initial begin
      int n;
      logic [63:0] c0;
      bus.ifu_ack = 0; bus.lsu_ack = 0; bus.lsu_err = 0;
      bus.jump_target = 32'h0; bus.mtvec = 32'h0; bus.mepc = 32'h0;
      clr_dec();

      cyc(); cyc();
      rst = 0;
      #1;
      chk("rst_pc", bus.pc, 64'h8000_0000);
      chk("rst_ifu_req", bus.ifu_req, 0);
      chk("rst_halt", bus.halt, 0);
      chk("rst_cycle_cnt", bus.cycle_cnt, 0);
      chk("rst_retire_cnt", bus.retire_cnt, 0);

      // add, ifu_ack on second FETCH cycle
      cyc();
      chk("fetch1_req", bus.ifu_req, 1);
      chk("cycle_cnt_1", bus.cycle_cnt, 1);
      cyc();
      chk("fetch2_req", bus.ifu_req, 1);
      bus.dec_reg_wen = 1;
      fetch();
      chk("add_exu_valid", bus.exu_valid, 1);
      chk("add_no_early_wen", bus.rf_wen, 0);
      cyc();
      chk("add_rf_wen", bus.rf_wen, 1);
      chk("add_retire", bus.retire, 1);
      chk("add_exu_off", bus.exu_valid, 0);
      cyc();
      chk("add_pc", bus.pc, 64'h8000_0004);
      chk("add_retire_cnt", bus.retire_cnt, 1);
      chk("add_retire_off", bus.retire, 0);

      // load, lsu_ack in 5th MEM cycle
      bus.dec_read = 1;
      fetch();
      cyc();
      for (int k = 1; k <= 5; k++) begin
         chk("ld_lsu_req", bus.lsu_req, 1);
         chk("ld_lsu_we", bus.lsu_we, 0);
         if (k == 5) bus.lsu_ack = 1;
         else cyc();
      end
      cyc();
      bus.lsu_ack = 0;
      #1;
      chk("ld_req_drop", bus.lsu_req, 0);
      chk("ld_rf_wen", bus.rf_wen, 1);
      cyc();
      chk("ld_pc", bus.pc, 64'h8000_0008);
      chk("ld_retire_cnt", bus.retire_cnt, 2);
      clr_dec();

      // aligned jump
      bus.jump = 1; bus.jump_target = 32'h8000_0100;
      fetch();
      cyc();
      chk("jmp_retire", bus.retire, 1);
      cyc();
      chk("jmp_pc", bus.pc, 64'h8000_0100);
      clr_dec();

      // ecall
      bus.dec_intr = 1; bus.dec_reg_wen = 1; bus.mtvec = 32'h8000_0800;
      fetch();
      cyc();
      chk("ecall_trap", bus.trap_take, 1);
      chk("ecall_rf_wen", bus.rf_wen, 0);
      chk("ecall_retire", bus.retire, 1);
      cyc();
      chk("ecall_pc", bus.pc, 64'h8000_0800);
      chk("ecall_trap_pulse", bus.trap_take, 0);
      clr_dec();

      // mret beats jump; also commits a CSR write
      bus.dec_mret = 1; bus.dec_csr_wen = 1; bus.mepc = 32'h8000_0010;
      bus.jump = 1; bus.jump_target = 32'h8000_0200;
      fetch();
      cyc();
      chk("mret_csr_wen", bus.csr_wen, 1);
      cyc();
      chk("mret_pc", bus.pc, 64'h8000_0010);
      chk("mret_retire_cnt", bus.retire_cnt, 5);
      clr_dec();

      // misaligned jump target
      bus.jump = 1; bus.jump_target = 32'h8000_0102; bus.dec_reg_wen = 1;
      fetch();
      cyc();
      chk("mis_retire", bus.retire, 0);
      chk("mis_rf_wen", bus.rf_wen, 0);
      cyc();
      chk("mis_halt", bus.halt, 1);
      chk("mis_halt_err", bus.halt_err, 1);
      chk("mis_pc", bus.pc, 64'h8000_0010);
      chk("mis_retire_cnt", bus.retire_cnt, 5);
      clr_dec();

      do_reset();
      chk("rst2_pc", bus.pc, 64'h8000_0000);
      chk("rst2_halt", bus.halt, 0);
      chk("rst2_halt_err", bus.halt_err, 0);
      chk("rst2_retire_cnt", bus.retire_cnt, 0);

      // store never acknowledged
      cyc();
      bus.dec_write = 1;
      fetch();
      cyc();
      chk("st_lsu_we", bus.lsu_we, 1);
      n = 0;
      while (bus.lsu_req && n < 400) begin
         n++;
         cyc();
      end
      chk("st_timeout_cycles", n, 255);
      chk("st_halt", bus.halt, 1);
      chk("st_halt_err", bus.halt_err, 1);
      clr_dec();

      // reset in the middle of MEM; stray lsu_ack in IDLE
      do_reset();
      cyc();
      bus.dec_read = 1;
      fetch();
      cyc();
      cyc();
      chk("mid_lsu_req", bus.lsu_req, 1);
      rst = 1;
      cyc();
      chk("mid_lsu_req_drop", bus.lsu_req, 0);
      chk("mid_pc", bus.pc, 64'h8000_0000);
      rst = 0;
      bus.lsu_ack = 1;
      cyc();
      bus.lsu_ack = 0;
      #1;
      chk("idle_ack_ignored_fetch", bus.ifu_req, 1);
      chk("idle_ack_ignored_lsu", bus.lsu_req, 0);
      clr_dec();

      // ebreak
      bus.dec_halt = 1;
      fetch();
      cyc();
      chk("ebreak_halt", bus.halt, 1);
      chk("ebreak_halt_err", bus.halt_err, 0);
      c0 = bus.cycle_cnt;
      cyc(); cyc(); cyc();
      chk("ebreak_cycle_cnt", bus.cycle_cnt, c0 + 64'd3);
      chk("ebreak_pc", bus.pc, 64'h8000_0000);
      chk("ebreak_ifu_req", bus.ifu_req, 0);
      clr_dec();

      // illegal instruction
      do_reset();
      cyc();
      bus.dec_illegal = 1;
      fetch();
      cyc();
      chk("ill_halt", bus.halt, 1);
      chk("ill_halt_err", bus.halt_err, 1);
      clr_dec();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
